// File: rtl/tcdm_master_pkg.sv
// Shared types and width defaults for the TCDM stream master and its response FIFO.
package tcdm_master_pkg;

    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

    typedef struct packed {
        logic [TCDM_ADDR_WIDTH-1:0] add;
        logic                       wen;
        logic [TCDM_BE_WIDTH-1:0]   be;
        logic [TCDM_DATA_WIDTH-1:0] data;
    } tcdm_cmd_t;

    typedef struct packed {
        logic [TCDM_DATA_WIDTH-1:0] data;
    } tcdm_rsp_t;

    // A depth-1 FIFO still needs a one-bit pointer to stay legal.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tcdm_rsp_fifo.sv
// Flop-based first-word-fall-through FIFO holding captured TCDM read data until consumed.
module tcdm_rsp_fifo
    import tcdm_master_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Clear wins over push and pop so a pending capture can never reappear afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tcdm_stream_master.sv
// Valid/ready command stream to TCDM req/gnt adapter; read data is credit-limited into a response FIFO.
module tcdm_stream_master
    import tcdm_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = TCDM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = TCDM_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = 2,
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1),
    localparam int unsigned OCC_W     = CNT_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_add_i,
    input  logic                  cmd_wen_i,
    input  logic [BE_WIDTH-1:0]   cmd_be_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [BE_WIDTH-1:0]   tcdm_be_o,
    output logic [DATA_WIDTH-1:0] tcdm_data_o,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  busy_o
);

    logic             rd_pending_q;
    logic             rd_granted;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [OCC_W-1:0] in_flight;
    logic             has_credit;

    // Every read either waits in the FIFO or is one cycle from landing there; both use a slot.
    assign in_flight  = OCC_W'(fifo_count) + OCC_W'(rd_pending_q);
    assign has_credit = in_flight < OCC_W'(RSP_DEPTH);

    assign tcdm_req_o  = cmd_valid_i & (~cmd_wen_i | has_credit);
    assign cmd_ready_o = tcdm_req_o & tcdm_gnt_i;
    assign rd_granted  = cmd_ready_o & cmd_wen_i;

    assign tcdm_add_o  = cmd_add_i;
    assign tcdm_wen_o  = cmd_wen_i;
    assign tcdm_be_o   = cmd_be_i;
    assign tcdm_data_o = cmd_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pending_q <= 1'b0;
        end else if (clear_i) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_granted;
        end
    end

    tcdm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) i_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (clear_i),
        .push      (rd_pending_q),
        .push_data (tcdm_r_data_i),
        .pop       (rsp_valid_o & rsp_ready_i),
        .pop_data  (rsp_data_o),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rsp_valid_o = ~fifo_empty;
    assign busy_o      = rd_pending_q | (fifo_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (in_flight <= OCC_W'(RSP_DEPTH));
            assert (!(rd_pending_q && fifo_full && !clear_i));
        end
    end

endmodule

// File: tb/tb_tcdm_stream_master.sv
// Directed bench for tcdm_stream_master with a small byte-enabled TCDM bank model.
module tb_tcdm_stream_master;
    import tcdm_master_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_add_i;
    logic        cmd_wen_i;
    logic [3:0]  cmd_be_i;
    logic [31:0] cmd_data_i;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic [31:0] tcdm_r_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] exp_word [4];

    always #5 clk_i = ~clk_i;

    tcdm_stream_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RSP_DEPTH  (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_add_i     (cmd_add_i),
        .cmd_wen_i     (cmd_wen_i),
        .cmd_be_i      (cmd_be_i),
        .cmd_data_i    (cmd_data_i),
        .tcdm_req_o    (tcdm_req_o),
        .tcdm_gnt_i    (tcdm_gnt_i),
        .tcdm_add_o    (tcdm_add_o),
        .tcdm_wen_o    (tcdm_wen_o),
        .tcdm_be_o     (tcdm_be_o),
        .tcdm_data_o   (tcdm_data_o),
        .tcdm_r_data_i (tcdm_r_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .busy_o        (busy_o)
    );

    // TCDM bank: word-indexed by add[5:2], read data returned one cycle after the grant.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            tcdm_r_data_i <= '0;
        end else if (tcdm_req_o && tcdm_gnt_i) begin
            if (tcdm_wen_o) begin
                tcdm_r_data_i <= mem[tcdm_add_o[5:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (tcdm_be_o[b]) mem[tcdm_add_o[5:2]][8*b +: 8] <= tcdm_data_o[8*b +: 8];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic apply_stimulus(input tcdm_cmd_t cmd, input logic valid);
        cmd_valid_i = valid;
        cmd_add_i   = cmd.add;
        cmd_wen_i   = cmd.wen;
        cmd_be_i    = cmd.be;
        cmd_data_i  = cmd.data;
    endtask

    function automatic tcdm_cmd_t rd(input logic [31:0] add);
        return '{add: add, wen: 1'b1, be: 4'hF, data: 32'h0};
    endfunction

    function automatic tcdm_cmd_t wr(input logic [31:0] add, input logic [3:0] be, input logic [31:0] data);
        return '{add: add, wen: 1'b0, be: be, data: data};
    endfunction

    initial begin
        int k;
        int grants;
        int responses;
        exp_word[0] = 32'h11111111;
        exp_word[1] = 32'h22222222;
        exp_word[2] = 32'h33333333;
        exp_word[3] = 32'h44444444;

        rst_ni = 1'b0; clear_i = 1'b0; tcdm_gnt_i = 1'b1; rsp_ready_i = 1'b0;
        apply_stimulus(rd(32'h0), 1'b0);
        #1;
        check_output("reset_req", {31'b0, tcdm_req_o}, 32'd0);
        check_output("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_output("reset_busy", {31'b0, busy_o}, 32'd0);
        apply_stimulus(rd(32'h10), 1'b1);
        #1;
        check_output("reset_comb_req", {31'b0, tcdm_req_o}, 32'd1);
        apply_stimulus(rd(32'h0), 1'b0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Write passes straight through and handshakes in the grant cycle.
        apply_stimulus(wr(32'h10, 4'b0011, 32'hDEADBEEF), 1'b1);
        #1;
        check_output("wr_req", {31'b0, tcdm_req_o}, 32'd1);
        check_output("wr_ready", {31'b0, cmd_ready_o}, 32'd1);
        check_output("wr_add", tcdm_add_o, 32'h10);
        check_output("wr_wen", {31'b0, tcdm_wen_o}, 32'd0);
        check_output("wr_be", {28'b0, tcdm_be_o}, 32'h3);
        check_output("wr_data", tcdm_data_o, 32'hDEADBEEF);
        tick();
        apply_stimulus(wr(32'h20, 4'hF, exp_word[0]), 1'b1);
        check_output("wr_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        check_output("wr_not_busy", {31'b0, busy_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(wr(32'h20 + 32'(4 * i), 4'hF, exp_word[i]), 1'b1);
            #1;
            check_output("wr_b2b_ready", {31'b0, cmd_ready_o}, 32'd1);
            tick();
        end

        // Read stalled by the bank for three cycles.
        apply_stimulus(rd(32'h10), 1'b1);
        tcdm_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("stall_req", {31'b0, tcdm_req_o}, 32'd1);
            check_output("stall_ready", {31'b0, cmd_ready_o}, 32'd0);
            tick();
        end
        tcdm_gnt_i = 1'b1;
        #1;
        check_output("stall_granted", {31'b0, cmd_ready_o}, 32'd1);
        tick();
        apply_stimulus(rd(32'h0), 1'b0);
        #1;
        check_output("rd_capture_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        check_output("rd_capture_busy", {31'b0, busy_o}, 32'd1);
        tick();
        check_output("rd_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check_output("rd_rsp_data", rsp_data_o, 32'h0000BEEF);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check_output("rd_popped", {31'b0, rsp_valid_o}, 32'd0);
        check_output("rd_idle", {31'b0, busy_o}, 32'd0);

        // Credit exhaustion with the response side stalled.
        apply_stimulus(rd(32'h20), 1'b1);
        #1;
        check_output("cr0_ready", {31'b0, cmd_ready_o}, 32'd1);
        tick();
        apply_stimulus(rd(32'h24), 1'b1);
        #1;
        check_output("cr1_ready", {31'b0, cmd_ready_o}, 32'd1);
        tick();
        apply_stimulus(rd(32'h28), 1'b1);
        #1;
        check_output("cr2_req_blocked", {31'b0, tcdm_req_o}, 32'd0);
        tick();
        #1;
        check_output("cr3_req_blocked", {31'b0, tcdm_req_o}, 32'd0);
        check_output("cr3_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check_output("cr3_rsp_data", rsp_data_o, exp_word[0]);
        rsp_ready_i = 1'b1;
        #1;
        check_output("cr3_req_during_pop", {31'b0, tcdm_req_o}, 32'd0);
        tick();
        rsp_ready_i = 1'b0;
        #1;
        check_output("cr4_req_after_pop", {31'b0, tcdm_req_o}, 32'd1);
        check_output("cr4_ready", {31'b0, cmd_ready_o}, 32'd1);
        check_output("cr4_rsp_data", rsp_data_o, exp_word[1]);
        tick();
        apply_stimulus(rd(32'h2C), 1'b1);
        #1;
        check_output("cr5_req_blocked", {31'b0, tcdm_req_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        #1;
        check_output("cr6_ready", {31'b0, cmd_ready_o}, 32'd1);
        check_output("cr6_rsp_data", rsp_data_o, exp_word[2]);
        tick();
        apply_stimulus(rd(32'h0), 1'b0);
        #1;
        check_output("cr7_rsp_empty", {31'b0, rsp_valid_o}, 32'd0);
        check_output("cr7_busy", {31'b0, busy_o}, 32'd1);
        tick();
        check_output("cr8_rsp_data", rsp_data_o, exp_word[3]);
        tick();
        check_output("cr9_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_output("cr9_busy", {31'b0, busy_o}, 32'd0);

        // Streaming reads with an always-ready consumer; responses must come back in order.
        k = 0; grants = 0; responses = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            apply_stimulus(rd(32'h20 + 32'(4 * k)), cyc < 12);
            #1;
            if (rsp_valid_o) begin
                check_output("stream_order", rsp_data_o, (exp_q.size() > 0) ? exp_q[0] : 32'hxxxxxxxx);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                responses++;
            end
            if (cmd_ready_o) begin
                exp_q.push_back(exp_word[k]);
                k = (k + 1) % 4;
                grants++;
            end
            tick();
        end
        check_output("stream_grants_min", {31'b0, grants >= 6}, 32'd1);
        check_output("stream_rsp_count", 32'(responses), 32'(grants));
        check_output("stream_drained", {31'b0, busy_o}, 32'd0);
        rsp_ready_i = 1'b0;

        // Clear in the capture cycle discards the read; a write still gets through.
        apply_stimulus(rd(32'h20), 1'b1);
        #1;
        check_output("clr_rd_ready", {31'b0, cmd_ready_o}, 32'd1);
        tick();
        apply_stimulus(wr(32'h30, 4'hF, 32'hCAFEF00D), 1'b1);
        clear_i = 1'b1;
        #1;
        check_output("clr_busy_before", {31'b0, busy_o}, 32'd1);
        check_output("clr_wr_ready", {31'b0, cmd_ready_o}, 32'd1);
        tick();
        clear_i = 1'b0;
        apply_stimulus(rd(32'h0), 1'b0);
        #1;
        check_output("clr_busy_after", {31'b0, busy_o}, 32'd0);
        check_output("clr_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        tick();
        check_output("clr_no_rsp_later", {31'b0, rsp_valid_o}, 32'd0);

        // Async reset with two responses queued.
        apply_stimulus(rd(32'h20), 1'b1);
        tick();
        apply_stimulus(rd(32'h24), 1'b1);
        tick();
        apply_stimulus(rd(32'h0), 1'b0);
        tick();
        check_output("rst_queued_valid", {31'b0, rsp_valid_o}, 32'd1);
        check_output("rst_queued_busy", {31'b0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_output("rst_async_valid", {31'b0, rsp_valid_o}, 32'd0);
        check_output("rst_async_busy", {31'b0, busy_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check_output("rst_after_valid", {31'b0, rsp_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
